// File: rtl/hier_fanin_collector.sv
// hier_fanin_collector
// Merges result beats from N_CHILD child instances into one parent-facing
// stream. A round-robin arbiter picks one eligible child per cycle. Each
// accepted beat is tagged with its source index. The block tracks which
// children have sent their final beat, counts delivered beats with
// saturation, and flags completion once every child is finished and the
// output register has drained.
module hier_fanin_collector #(
  parameter int N_CHILD = 5,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 3,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CHILD-1:0]        child_valid,
  input  logic [N_CHILD*DATA_W-1:0] child_data,
  input  logic [N_CHILD-1:0]        child_last,
  output logic [N_CHILD-1:0]        child_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_idx,
  output logic                      out_last,
  input  logic                      out_ready,
  input  logic                      clear,
  output logic [N_CHILD-1:0]        done_mask,
  output logic                      all_done,
  output logic [CNT_W-1:0]          beat_count
);

  logic [IDX_W-1:0]  rr_ptr;
  logic [N_CHILD-1:0] eligible;
  logic              found;
  logic [IDX_W-1:0]  grant;
  logic [DATA_W-1:0] sel_data;
  logic              sel_last;
  logic              load_en;
  logic              accept;
  logic              drain;

  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [IDX_W-1:0]  idx_p1;
  logic              last_p1;

  // Saturating increment: the counter sticks at all ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Pointer advance, wrapping from the last child back to child 0.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == IDX_W'(N_CHILD - 1)) ? '0 : g + 1'b1;
  endfunction

  assign eligible = child_valid & ~done_mask;
  assign load_en  = !vld_p1 || out_ready;
  assign accept   = found && load_en && !rst;
  assign drain    = vld_p1 && out_ready;

  // Round-robin scan starting at rr_ptr; first eligible child wins and its payload is muxed out.
  always_comb begin
    int scan;
    scan     = 0;
    found    = 1'b0;
    grant    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < N_CHILD; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= N_CHILD) scan = scan - N_CHILD;
      if (!found && eligible[scan]) begin
        found    = 1'b1;
        grant    = IDX_W'(scan);
        sel_data = child_data[scan*DATA_W +: DATA_W];
        sel_last = child_last[scan];
      end
    end
  end

  // One-hot accept toward the granted child; zero under reset, backpressure or no request.
  always_comb begin
    child_ready = '0;
    if (accept) child_ready[grant] = 1'b1;
  end

  // Stage p1: output register, a one-entry pipeline slot that refills on drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      idx_p1  <= '0;
      last_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      idx_p1  <= grant;
      last_p1 <= sel_last;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  // Arbitration pointer moves just past the child that was served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= next_ptr(grant);
    end
  end

  // End-of-stream tracking and completion; clear wins over a same-cycle last beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      done_mask <= '0;
      all_done  <= 1'b0;
    end else begin
      if (clear) begin
        done_mask <= '0;
      end else if (accept && sel_last) begin
        done_mask <= done_mask | child_ready;
      end
      all_done <= (&done_mask) && !vld_p1 && !clear;
    end
  end

  // Delivered-beat counter; clear drops any same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_count <= '0;
    end else if (clear) begin
      beat_count <= '0;
    end else if (drain) begin
      beat_count <= sat_inc(beat_count);
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_idx   = idx_p1;
  assign out_last  = last_p1;

endmodule

// File: tb/tb_hier_fanin_collector.sv
// Testbench for hier_fanin_collector: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model of the
// arbitration, end-of-stream and counting rules.
module tb_hier_fanin_collector;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    child_valid;
  logic [N*DW-1:0] child_data;
  logic [N-1:0]    child_last;
  logic [N-1:0]    child_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            out_ready;
  logic            clear;
  logic [N-1:0]    done_mask;
  logic            all_done;
  logic [CW-1:0]   beat_count;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int            m_ptr   = 0;
  bit [N-1:0]    m_done  = '0;
  int            m_count = 0;
  bit            m_vld   = 1'b0;
  logic [DW-1:0] m_data  = '0;
  int            m_idx   = 0;
  bit            m_last  = 1'b0;
  bit            m_all   = 1'b0;

  logic [N-1:0]  exp_oh;

  hier_fanin_collector #(
    .N_CHILD(N), .DATA_W(DW), .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .child_valid(child_valid), .child_data(child_data), .child_last(child_last),
    .child_ready(child_ready),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .out_ready(out_ready), .clear(clear),
    .done_mask(done_mask), .all_done(all_done), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // First requesting, not-yet-finished child at or after the pointer, modulo N.
  function automatic int model_grant();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (child_valid[i] && !m_done[i]) return i;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] l,
                       input logic ordy, input logic clr);
    child_valid = v;
    child_last  = l;
    out_ready   = ordy;
    clear       = clr;
    for (int i = 0; i < N; i++) child_data[i*DW +: DW] = DW'(16'h1000 + i);
  endtask

  // One clock: check ready against the model, advance the model, check outputs after the edge.
  task automatic step();
    int         g;
    bit         load, acc, drained, all_next;
    bit [N-1:0] exp_rdy;
    #1;
    g    = model_grant();
    load = !m_vld || out_ready;
    acc  = (g >= 0) && load && !rst;
    exp_rdy = '0;
    if (acc) exp_rdy[g] = 1'b1;
    check("child_ready", child_ready, exp_rdy);
    if (rst) begin
      m_ptr = 0; m_done = '0; m_count = 0; m_vld = 0;
      m_data = '0; m_idx = 0; m_last = 0; m_all = 0;
    end else begin
      drained  = m_vld && out_ready;
      all_next = (m_done == '1) && !m_vld && !clear;
      if (clear) m_count = 0;
      else if (drained && m_count < CMAX) m_count++;
      if (clear) m_done = '0;
      else if (acc && child_last[g]) m_done[g] = 1'b1;
      if (acc) begin
        m_data = child_data[g*DW +: DW];
        m_idx  = g;
        m_last = child_last[g];
        m_vld  = 1'b1;
        m_ptr  = (g + 1) % N;
      end else if (drained) begin
        m_vld = 1'b0;
      end
      m_all = all_next;
    end
    @(posedge clk);
    #1;
    check("out_valid",  out_valid,  m_vld);
    check("out_data",   out_data,   m_data);
    check("out_idx",    out_idx,    m_idx);
    check("out_last",   out_last,   m_last);
    check("done_mask",  done_mask,  m_done);
    check("all_done",   all_done,   m_all);
    check("beat_count", beat_count, m_count);
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    drive('0, '0, 1'b0, 1'b0);
    step();
    step();
    check("rst_out_valid",  out_valid,  1'b0);
    check("rst_done_mask",  done_mask,  '0);
    check("rst_beat_count", beat_count, '0);
    rst = 1'b0;

    // All children valid, continuous out_ready: round-robin 0..4, one beat per cycle
    drive('1, '0, 1'b1, 1'b0);
    for (int n = 0; n < 11; n++) begin
      step();
      check("rr_seq_idx",  out_idx,  n % N);
      check("rr_seq_data", out_data, 16'h1000 + (n % N));
    end
    check("rr_seq_count", beat_count, 10);

    // Pointer at 3 with only children 1 and 4 requesting: 4, 1, 4
    rst = 1'b1; drive('0, '0, 1'b0, 1'b0); step(); rst = 1'b0;
    drive(5'b00100, '0, 1'b1, 1'b0);
    step();
    drive(5'b10010, '0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      exp_oh = (k % 2 == 0) ? 5'b10000 : 5'b00010;
      check("wrap_onehot", child_ready, exp_oh);
      step();
    end

    // Backpressure: beat 0x00AB from child 2 held for 4 cycles
    drive(5'b00100, '0, 1'b1, 1'b0);
    child_data[2*DW +: DW] = 16'h00AB;
    step();
    drive('1, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("hold_data",  out_data,    16'h00AB);
      check("hold_idx",   out_idx,     2);
      check("hold_ready", child_ready, '0);
    end
    drive('1, '0, 1'b1, 1'b0);
    step();
    check("release_valid", out_valid, 1'b1);
    check("release_idx",   out_idx,   3);

    // Two beats per child, second with last; later requests ignored
    rst = 1'b1; drive('0, '0, 1'b0, 1'b0); step(); rst = 1'b0;
    drive('1, '0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    drive('1, '1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("eos_mask", done_mask, 5'b11111);
    for (int k = 0; k < 3; k++) step();
    check("eos_all_done", all_done, 1'b1);
    check("eos_count",    beat_count, 10);

    // clear coinciding with child 0's last-beat accept
    drive('0, '0, 1'b0, 1'b1);
    step();
    drive(5'b00001, 5'b00001, 1'b1, 1'b1);
    step();
    check("clr_out_last", out_last,   1'b1);
    check("clr_mask",     done_mask,  '0);
    check("clr_count",    beat_count, '0);
    drive('0, '0, 1'b1, 1'b0);
    step();
    step();
    check("clr_all_done", all_done, 1'b0);

    // Saturation at 15, then reset mid-stream
    rst = 1'b1; drive('0, '0, 1'b0, 1'b0); step(); rst = 1'b0;
    drive('1, '0, 1'b1, 1'b0);
    for (int k = 0; k < 21; k++) step();
    check("sat_count", beat_count, CMAX);
    check("sat_valid", out_valid,  1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_valid", out_valid,  1'b0);
    check("midrst_count", beat_count, '0);
    check("midrst_mask",  done_mask,  '0);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom % 64) == 0;
      drive(N'($urandom), N'($urandom & $urandom & $urandom),
            ($urandom % 4) != 0, ($urandom % 32) == 0);
      for (int i = 0; i < N; i++) child_data[i*DW +: DW] = DW'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hier_fanin_collector.md
Name: hier_fanin_collector

Overview:
- Return-path counterpart to the generated hierarchy fan-out, where one parent instantiates N child instances.
- Gathers result beats from N child instances into a single parent-facing stream using round-robin arbitration.
- Tags each beat with the source child index and tracks per-child end-of-stream.
- Raises a completion flag once every child has finished and the output has drained.

Parameters:
- N_CHILD, 5, number of child instances merged (2..8).
- DATA_W, 16, payload width per beat.
- IDX_W, 3, width of the child-index tag; must satisfy 2^IDX_W >= N_CHILD.
- CNT_W, 16, width of the saturating beat counter.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- child_valid  input  N_CHILD  per-child beat valid.
- child_data  input  N_CHILD*DATA_W  per-child payload; child i occupies bits [i*DATA_W +: DATA_W].
- child_last  input  N_CHILD  per-child final-beat marker, qualified by child_valid.
- child_ready  output  N_CHILD  per-child accept, one-hot or zero, combinational.
- out_valid  output  1  merged beat valid (registered).
- out_data  output  DATA_W  merged payload.
- out_idx  output  IDX_W  source child index of the current beat.
- out_last  output  1  copy of the source child_last for this beat.
- out_ready  input  1  downstream accept.
- clear  input  1  synchronous pulse; restarts end-of-stream tracking and the beat counter.
- done_mask  output  N_CHILD  children that have delivered their last beat.
- all_done  output  1  completion flag (registered).
- beat_count  output  CNT_W  number of beats delivered downstream.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - done_mask=0, all_done=0, beat_count=0.
  - Round-robin pointer rr_ptr=0.
  - child_ready is combinationally 0 while rst=1.
  - Reset mid-transfer discards the held beat with no output.
- Load enable: load_en = !out_valid || out_ready. This makes the output register a one-entry pipeline stage that sustains 1 beat/cycle under continuous out_ready.
- Eligibility: child i is eligible when child_valid[i]=1 and done_mask[i]=0.
  - Valid from a done child is ignored, and its child_ready stays 0.
- Grant: the first eligible child scanning rr_ptr, rr_ptr+1, ..., wrapping modulo N_CHILD.
  - child_ready[grant]=load_en; all other bits are 0.
  - With no eligible child, child_ready=0.
  - child_ready may depend on child_valid (no combinational loop is permitted through child_valid).
- Accept: a transfer occurs when child_valid[i] && child_ready[i]. On that edge:
  - out_data, out_idx and out_last load from child i, and out_valid goes to 1.
  - rr_ptr becomes (i+1) mod N_CHILD; from N_CHILD-1 it wraps to 0.
- Latency: exactly 1 cycle from accept to out_valid.
- Drain: if out_valid && out_ready and nothing is accepted, out_valid goes to 0 next cycle.
  - A simultaneous drain and accept keeps out_valid=1 with the new beat.
- Output hold: while out_valid=1 and out_ready=0, out_data, out_idx and out_last are held stable.
- done_mask:
  - Bit i sets on an accept from child i with child_last[i]=1.
  - clear zeroes the whole mask and has priority over a same-cycle set; the beat itself is still transferred.
- all_done: registered; all_done <= (done_mask all ones) && !out_valid && !clear.
  - It therefore rises 1 cycle after the final beat drains.
  - It stays high until clear or rst.
- beat_count:
  - Increments on each out_valid && out_ready.
  - Saturates at 2^CNT_W-1.
  - clear sets it to 0, and a same-cycle increment is lost.
- Idle parent: with out_ready held 0 and out_valid=1, child_ready=0 for all children, giving full backpressure with no loss.

Test Plan:
- Reset, then all 5 children valid with data=0x1000+i and out_ready=1 constantly:
  - out_idx sequence is 0,1,2,3,4,0,...
  - one beat per cycle; out_data matches the tag.
  - beat_count=10 after 10 cycles.
- rr_ptr=3 with only children 1 and 4 valid:
  - grant goes to 4, then 1 (wrap), then 4.
  - child_ready is one-hot every accept cycle.
- out_ready=0 for 4 cycles with beat 0x00AB from child 2 held:
  - out_data stays 0x00AB and out_idx stays 2.
  - child_ready=0 throughout.
  - on release, the next beat appears 1 cycle later.
- Each child sends 2 beats, the second with last=1:
  - done_mask builds to 5'b11111.
  - further child_valid from those children is ignored.
  - all_done rises 1 cycle after the final drain.
- clear in the same cycle as child 0's last-beat accept:
  - beat is delivered with out_last=1, but done_mask[0]=0 afterwards.
  - beat_count=0 afterwards.
  - all_done stays 0.
- With CNT_W=4, deliver 20 beats:
  - beat_count saturates at 15.
  - rst asserted mid-stream with out_valid=1 gives out_valid=0, beat_count=0, done_mask=0 on the next cycle.
